keypad_lock_ctrl: RTL and testbench

Sequencing controller that sits directly behind the 4x4 keypad scanner. It consumes the scanner's one-cycle `key_valid` pulse and 4-bit key code, assembles a PW_LEN-digit entry, and checks it against a stored password. It manages the locked, unlocked, password-change and lockout states, and drives the display digits and lock/alarm indicators.

---
 rtl/keypad_lock_ctrl_if.sv | 20 ++
 rtl/keypad_lock_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_keypad_lock_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_lock_ctrl_if.sv
// keypad_lock_ctrl_if
// Key-press channel between the 4x4 keypad scanner and the lock controller.
//   key_valid : one-cycle pulse, a new key has been pressed
//   key_code  : 4-bit key value, meaningful only while key_valid=1
// The scanner drives the channel through the master modport; the lock
// controller consumes it through the slave modport.
interface keypad_lock_ctrl_if;
    logic       key_valid;
    logic [3:0] key_code;

    modport master (
        output key_valid,
        output key_code
    );

    modport slave (
        input key_valid,
        input key_code
    );
endinterface

// File: rtl/keypad_lock_ctrl.sv
// keypad_lock_ctrl
// Sequencing controller behind the keypad scanner. It assembles a PW_LEN-digit
// entry, checks it against the stored password, and manages the locked,
// unlocked, password-change and lockout (alarm) states.
// Ports:
//   clk          : system clock
//   reset        : asynchronous, active-low reset
//   key_if       : key-press channel from the scanner (slave side)
//   unlocked     : high in UNLOCKED and SET_PW
//   alarm        : high in ALARM
//   entry_digits : digits typed so far, newest in [3:0], unused positions 0
//   entry_cnt    : number of digits currently held (0..PW_LEN)
//   ok_pulse     : one cycle, password accepted or new password stored
//   err_pulse    : one cycle, check failed or short new password rejected
//   state        : LOCKED=0 ENTRY=1 CHECK=2 UNLOCKED=3 SET_PW=4 ALARM=5
module keypad_lock_ctrl #(
    parameter int                  PW_LEN         = 4,
    parameter logic [4*PW_LEN-1:0] DEFAULT_PW     = 16'h1234,
    parameter int                  MAX_TRIES      = 3,
    parameter int                  TIMEOUT_CYCLES = 50000000,
    parameter int                  LOCKOUT_CYCLES = 250000000
) (
    input  logic                  clk,
    input  logic                  reset,
    keypad_lock_ctrl_if.slave     key_if,
    output logic                  unlocked,
    output logic                  alarm,
    output logic [4*PW_LEN-1:0]   entry_digits,
    output logic [3:0]            entry_cnt,
    output logic                  ok_pulse,
    output logic                  err_pulse,
    output logic [2:0]            state
);

    localparam int EW     = 4 * PW_LEN;
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int LOCK_W = $clog2(LOCKOUT_CYCLES + 1);

    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCKOUT_CYCLES - 1);
    localparam logic [LOCK_W-1:0] LOCK_ONE  = LOCK_W'(1);
    localparam logic [3:0]        PW_CNT    = 4'(PW_LEN);
    localparam logic [2:0]        FAIL_MAX  = 3'(MAX_TRIES);

    localparam logic [3:0] KEY_BKSP   = 4'hb;
    localparam logic [3:0] KEY_CLEAR  = 4'hc;
    localparam logic [3:0] KEY_ENTER  = 4'hd;
    localparam logic [3:0] KEY_CHANGE = 4'he;
    localparam logic [3:0] KEY_RELOCK = 4'hf;

    typedef enum logic [2:0] {
        ST_LOCKED   = 3'd0,
        ST_ENTRY    = 3'd1,
        ST_CHECK    = 3'd2,
        ST_UNLOCKED = 3'd3,
        ST_SET_PW   = 3'd4,
        ST_ALARM    = 3'd5
    } state_t;

    state_t            state_r,        state_s;
    logic [EW-1:0]     pw_r,           pw_s;
    logic [EW-1:0]     entry_digits_r, entry_digits_s;
    logic [3:0]        entry_cnt_r,    entry_cnt_s;
    logic [2:0]        fail_cnt_r,     fail_cnt_s;
    logic [IDLE_W-1:0] idle_cnt_r,     idle_cnt_s;
    logic [LOCK_W-1:0] lock_cnt_r,     lock_cnt_s;
    logic              ok_pulse_r,     ok_pulse_s;
    logic              err_pulse_r,    err_pulse_s;

    logic              key_s;
    logic [3:0]        code_s;
    logic              digit_s;
    logic              full_s;
    logic              empty_s;
    logic              timeout_s;
    logic              match_s;
    logic [2:0]        fail_inc_s;
    logic [EW-1:0]     push_digits_s;
    logic [3:0]        push_cnt_s;
    logic [EW-1:0]     bksp_digits_s;
    logic [3:0]        bksp_cnt_s;

    assign key_s      = key_if.key_valid;
    assign code_s     = key_if.key_code;
    assign digit_s    = (code_s <= 4'd9);
    assign full_s     = (entry_cnt_r == PW_CNT);
    assign empty_s    = (entry_cnt_r == 4'd0);
    assign timeout_s  = (idle_cnt_r == IDLE_LAST);
    assign match_s    = full_s && (entry_digits_r == pw_r);
    assign fail_inc_s = fail_cnt_r + 3'd1;

    // A full entry swallows further digits; otherwise shift the new digit in at the bottom.
    assign push_digits_s = full_s  ? entry_digits_r : ((entry_digits_r << 4) | EW'(code_s));
    assign push_cnt_s    = full_s  ? entry_cnt_r    : (entry_cnt_r + 4'd1);
    assign bksp_digits_s = empty_s ? entry_digits_r : (entry_digits_r >> 4);
    assign bksp_cnt_s    = empty_s ? entry_cnt_r    : (entry_cnt_r - 4'd1);

    // Next-state, datapath and pulse decode for the lock sequencer.
    always_comb begin
        state_s        = state_r;
        pw_s           = pw_r;
        entry_digits_s = entry_digits_r;
        entry_cnt_s    = entry_cnt_r;
        fail_cnt_s     = fail_cnt_r;
        lock_cnt_s     = lock_cnt_r;
        ok_pulse_s     = 1'b0;
        err_pulse_s    = 1'b0;

        case (state_r)
            ST_LOCKED: begin
                if (key_s && digit_s) begin
                    entry_digits_s = push_digits_s;
                    entry_cnt_s    = push_cnt_s;
                    state_s        = ST_ENTRY;
                end else begin
                    state_s = ST_LOCKED;
                end
            end

            ST_ENTRY: begin
                if (key_s) begin
                    case (code_s)
                        KEY_BKSP: begin
                            entry_digits_s = bksp_digits_s;
                            entry_cnt_s    = bksp_cnt_s;
                            if (bksp_cnt_s == 4'd0) begin
                                state_s = ST_LOCKED;
                            end else begin
                                state_s = ST_ENTRY;
                            end
                        end
                        KEY_CLEAR: begin
                            entry_digits_s = '0;
                            entry_cnt_s    = 4'd0;
                            state_s        = ST_LOCKED;
                        end
                        KEY_ENTER: begin
                            state_s = ST_CHECK;
                        end
                        default: begin
                            if (digit_s) begin
                                entry_digits_s = push_digits_s;
                                entry_cnt_s    = push_cnt_s;
                            end else begin
                                state_s = ST_ENTRY;
                            end
                        end
                    endcase
                end else if (timeout_s) begin
                    // Abandoned entry; not counted as a failed try.
                    entry_digits_s = '0;
                    entry_cnt_s    = 4'd0;
                    state_s        = ST_LOCKED;
                end else begin
                    state_s = ST_ENTRY;
                end
            end

            ST_CHECK: begin
                // Keys arriving here are dropped; the verdict takes exactly this one cycle.
                entry_digits_s = '0;
                entry_cnt_s    = 4'd0;
                if (match_s) begin
                    ok_pulse_s = 1'b1;
                    fail_cnt_s = 3'd0;
                    state_s    = ST_UNLOCKED;
                end else begin
                    err_pulse_s = 1'b1;
                    fail_cnt_s  = fail_inc_s;
                    if (fail_inc_s == FAIL_MAX) begin
                        lock_cnt_s = LOCK_LAST;
                        state_s    = ST_ALARM;
                    end else begin
                        state_s = ST_LOCKED;
                    end
                end
            end

            ST_UNLOCKED: begin
                if (key_s && (code_s == KEY_RELOCK)) begin
                    state_s = ST_LOCKED;
                end else if (key_s && (code_s == KEY_CHANGE)) begin
                    entry_digits_s = '0;
                    entry_cnt_s    = 4'd0;
                    state_s        = ST_SET_PW;
                end else begin
                    state_s = ST_UNLOCKED;
                end
            end

            ST_SET_PW: begin
                if (key_s) begin
                    case (code_s)
                        KEY_BKSP: begin
                            entry_digits_s = bksp_digits_s;
                            entry_cnt_s    = bksp_cnt_s;
                        end
                        KEY_CLEAR: begin
                            entry_digits_s = '0;
                            entry_cnt_s    = 4'd0;
                        end
                        KEY_ENTER: begin
                            entry_digits_s = '0;
                            entry_cnt_s    = 4'd0;
                            if (full_s) begin
                                pw_s       = entry_digits_r;
                                ok_pulse_s = 1'b1;
                                state_s    = ST_UNLOCKED;
                            end else begin
                                err_pulse_s = 1'b1;
                                state_s     = ST_SET_PW;
                            end
                        end
                        KEY_RELOCK: begin
                            entry_digits_s = '0;
                            entry_cnt_s    = 4'd0;
                            state_s        = ST_UNLOCKED;
                        end
                        default: begin
                            if (digit_s) begin
                                entry_digits_s = push_digits_s;
                                entry_cnt_s    = push_cnt_s;
                            end else begin
                                state_s = ST_SET_PW;
                            end
                        end
                    endcase
                end else if (timeout_s) begin
                    entry_digits_s = '0;
                    entry_cnt_s    = 4'd0;
                    state_s        = ST_UNLOCKED;
                end else begin
                    state_s = ST_SET_PW;
                end
            end

            ST_ALARM: begin
                // Counter was loaded with LOCKOUT_CYCLES-1, so ALARM spans LOCKOUT_CYCLES cycles.
                if (lock_cnt_r == '0) begin
                    fail_cnt_s = 3'd0;
                    state_s    = ST_LOCKED;
                end else begin
                    lock_cnt_s = lock_cnt_r - LOCK_ONE;
                end
            end

            default: begin
                entry_digits_s = '0;
                entry_cnt_s    = 4'd0;
                state_s        = ST_LOCKED;
            end
        endcase
    end

    // Idle counter: restarts on any key press or state change, counts only while typing.
    always_comb begin
        idle_cnt_s = '0;
        if (key_s || (state_s != state_r)) begin
            idle_cnt_s = '0;
        end else if ((state_r == ST_ENTRY) || (state_r == ST_SET_PW)) begin
            idle_cnt_s = idle_cnt_r + IDLE_ONE;
        end else begin
            idle_cnt_s = '0;
        end
    end

    // State, password, entry, counters and pulse registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r        <= ST_LOCKED;
            pw_r           <= DEFAULT_PW;
            entry_digits_r <= '0;
            entry_cnt_r    <= 4'd0;
            fail_cnt_r     <= 3'd0;
            idle_cnt_r     <= '0;
            lock_cnt_r     <= '0;
            ok_pulse_r     <= 1'b0;
            err_pulse_r    <= 1'b0;
        end else begin
            state_r        <= state_s;
            pw_r           <= pw_s;
            entry_digits_r <= entry_digits_s;
            entry_cnt_r    <= entry_cnt_s;
            fail_cnt_r     <= fail_cnt_s;
            idle_cnt_r     <= idle_cnt_s;
            lock_cnt_r     <= lock_cnt_s;
            ok_pulse_r     <= ok_pulse_s;
            err_pulse_r    <= err_pulse_s;
        end
    end

    assign state        = state_r;
    assign unlocked     = (state_r == ST_UNLOCKED) || (state_r == ST_SET_PW);
    assign alarm        = (state_r == ST_ALARM);
    assign entry_digits = entry_digits_r;
    assign entry_cnt    = entry_cnt_r;
    assign ok_pulse     = ok_pulse_r;
    assign err_pulse    = err_pulse_r;

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// tb_keypad_lock_ctrl
// Drives directed and random key sequences into keypad_lock_ctrl and checks
// every cycle's outputs, plus every ok/err pulse, against a queue-based
// reference model of the lock rules.
module tb_keypad_lock_ctrl;

    localparam int PW_LEN    = 4;
    localparam int MAX_TRIES = 3;
    localparam int TIMEOUT   = 20;
    localparam int LOCKOUT   = 30;

    localparam int M_LOCKED   = 0;
    localparam int M_ENTRY    = 1;
    localparam int M_CHECK    = 2;
    localparam int M_UNLOCKED = 3;
    localparam int M_SET_PW   = 4;
    localparam int M_ALARM    = 5;

    logic        clk;
    logic        reset;
    logic        unlocked;
    logic        alarm;
    logic [15:0] entry_digits;
    logic [3:0]  entry_cnt;
    logic        ok_pulse;
    logic        err_pulse;
    logic [2:0]  state;

    keypad_lock_ctrl_if kif();

    keypad_lock_ctrl #(
        .PW_LEN         (PW_LEN),
        .DEFAULT_PW     (16'h1234),
        .MAX_TRIES      (MAX_TRIES),
        .TIMEOUT_CYCLES (TIMEOUT),
        .LOCKOUT_CYCLES (LOCKOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .key_if       (kif),
        .unlocked     (unlocked),
        .alarm        (alarm),
        .entry_digits (entry_digits),
        .entry_cnt    (entry_cnt),
        .ok_pulse     (ok_pulse),
        .err_pulse    (err_pulse),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  st;
        logic [15:0] ed;
        logic [3:0]  cnt;
        logic        unl;
        logic        alm;
        logic        ok;
        logic        err;
    } status_t;

    typedef struct packed {
        logic       is_ok;
        logic [2:0] st;
    } event_t;

    status_t status_q[$];
    event_t  event_q[$];
    int      checks;
    int      errors;

    // Reference model: typed digits oldest-first, password as a digit list.
    int   m_mode;
    int   m_dig[$];
    int   m_pw[$];
    int   m_fails;
    int   m_idle;
    int   m_alarm_t;
    logic m_ok;
    logic m_err;

    task automatic model_reset();
        m_mode = M_LOCKED;
        m_dig.delete();
        m_pw.delete();
        m_pw.push_back(1); m_pw.push_back(2); m_pw.push_back(3); m_pw.push_back(4);
        m_fails = 0; m_idle = 0; m_alarm_t = 0;
        m_ok = 1'b0; m_err = 1'b0;
    endtask

    function automatic bit entry_is_pw();
        if (m_dig.size() != m_pw.size()) return 1'b0;
        foreach (m_dig[i]) if (m_dig[i] != m_pw[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [15:0] entry_value();
        logic [15:0] v;
        v = 16'h0000;
        foreach (m_dig[i]) v = (v << 4) | 16'(m_dig[i]);
        return v;
    endfunction

    // Applies one clock edge's worth of the lock rules to the model.
    task automatic model_step(input logic kv, input logic [3:0] kc);
        int  prev;
        int  k;
        bit  is_d;
        prev  = m_mode;
        k     = int'(kc);
        is_d  = (k <= 9);
        m_ok  = 1'b0;
        m_err = 1'b0;
        case (m_mode)
            M_LOCKED: if (kv && is_d) begin m_dig.push_back(k); m_mode = M_ENTRY; end
            M_ENTRY, M_SET_PW: begin
                if (kv) begin
                    if (is_d) begin
                        if (m_dig.size() < PW_LEN) m_dig.push_back(k);
                    end else if (k == 11) begin
                        if (m_dig.size() > 0) void'(m_dig.pop_back());
                        if (m_mode == M_ENTRY && m_dig.size() == 0) m_mode = M_LOCKED;
                    end else if (k == 12) begin
                        m_dig.delete();
                        if (m_mode == M_ENTRY) m_mode = M_LOCKED;
                    end else if (k == 13) begin
                        if (m_mode == M_ENTRY) m_mode = M_CHECK;
                        else if (m_dig.size() == PW_LEN) begin
                            m_pw = m_dig; m_ok = 1'b1; m_dig.delete(); m_mode = M_UNLOCKED;
                        end else begin
                            m_err = 1'b1; m_dig.delete();
                        end
                    end else if (k == 15 && m_mode == M_SET_PW) begin
                        m_dig.delete(); m_mode = M_UNLOCKED;
                    end
                end else if (m_idle == TIMEOUT - 1) begin
                    m_dig.delete();
                    m_mode = (m_mode == M_ENTRY) ? M_LOCKED : M_UNLOCKED;
                end else begin
                    m_idle++;
                end
            end
            M_CHECK: begin
                if (entry_is_pw()) begin
                    m_ok = 1'b1; m_fails = 0; m_mode = M_UNLOCKED;
                end else begin
                    m_err = 1'b1; m_fails++;
                    if (m_fails == MAX_TRIES) begin m_mode = M_ALARM; m_alarm_t = 0; end
                    else m_mode = M_LOCKED;
                end
                m_dig.delete();
            end
            M_UNLOCKED: begin
                if (kv && k == 15) m_mode = M_LOCKED;
                else if (kv && k == 14) begin m_dig.delete(); m_mode = M_SET_PW; end
            end
            M_ALARM: begin
                m_alarm_t++;
                if (m_alarm_t == LOCKOUT) begin m_fails = 0; m_mode = M_LOCKED; end
            end
            default: m_mode = M_LOCKED;
        endcase
        if (kv || m_mode != prev) m_idle = 0;
    endtask

    function automatic status_t model_status();
        status_t s;
        s.st  = 3'(m_mode);
        s.ed  = entry_value();
        s.cnt = 4'(m_dig.size());
        s.unl = (m_mode == M_UNLOCKED) || (m_mode == M_SET_PW);
        s.alm = (m_mode == M_ALARM);
        s.ok  = m_ok;
        s.err = m_err;
        return s;
    endfunction

    // One clock of stimulus: drive, advance the model, queue what the DUT must show.
    task automatic step(input logic kv, input logic [3:0] kc);
        status_t s;
        event_t  e;
        kif.key_valid = kv;
        kif.key_code  = kc;
        model_step(kv, kc);
        s = model_status();
        e.is_ok = m_ok;
        e.st    = 3'(m_mode);
        @(posedge clk);
        #1;
        kif.key_valid = 1'b0;
        status_q.push_back(s);
        if (m_ok || m_err) event_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 4'h0);
    endtask

    // Sends n keys packed as nibbles, first key in the most significant used nibble.
    task automatic send_seq(input logic [31:0] seq, input int n);
        logic [31:0] w;
        w = seq;
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b1, w[4*i +: 4]);
            step(1'b0, 4'h0);
        end
        step(1'b0, 4'h0);
    endtask

    task automatic send_pw();
        int p[$];
        p = m_pw;
        foreach (p[i]) step(1'b1, 4'(p[i]));
        step(1'b1, 4'hd);
        idle(2);
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (state !== 3'd0 || unlocked !== 1'b0 || alarm !== 1'b0) begin
            errors++;
            $display("FAIL %s_state: got state=%0d unlocked=%b alarm=%b, need 0/0/0", tag, state, unlocked, alarm);
        end
        checks++;
        if (entry_digits !== 16'h0000 || entry_cnt !== 4'd0) begin
            errors++;
            $display("FAIL %s_entry: got %h cnt=%0d, need 0000 cnt=0", tag, entry_digits, entry_cnt);
        end
        checks++;
        if (ok_pulse !== 1'b0 || err_pulse !== 1'b0) begin
            errors++;
            $display("FAIL %s_pulses: got ok=%b err=%b, need 0/0", tag, ok_pulse, err_pulse);
        end
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic random_phase(input int n);
        int act;
        for (int r = 0; r < n; r++) begin
            act = int'($urandom_range(0, 9));
            if (act < 5) begin
                step(1'b1, 4'($urandom_range(0, 15)));
            end else if (act < 7) begin
                send_pw();
            end else if (act == 7) begin
                step(1'b1, 4'he);
                repeat ($urandom_range(2, 5)) step(1'b1, 4'($urandom_range(0, 9)));
                step(1'b1, 4'hd);
            end else begin
                idle(int'($urandom_range(1, 25)));
            end
        end
    endtask

    // Monitor: compares each cycle's outputs and every result pulse against the queues.
    always @(negedge clk) begin
        status_t exp_s;
        status_t act_s;
        event_t  exp_e;
        if (status_q.size() > 0) begin
            exp_s = status_q.pop_front();
            act_s = {state, entry_digits, entry_cnt, unlocked, alarm, ok_pulse, err_pulse};
            checks++;
            if (act_s !== exp_s) begin
                errors++;
                $display("FAIL status @%0t: got st=%0d ed=%h cnt=%0d unl=%b alm=%b ok=%b err=%b, need st=%0d ed=%h cnt=%0d unl=%b alm=%b ok=%b err=%b",
                         $time, act_s.st, act_s.ed, act_s.cnt, act_s.unl, act_s.alm, act_s.ok, act_s.err,
                         exp_s.st, exp_s.ed, exp_s.cnt, exp_s.unl, exp_s.alm, exp_s.ok, exp_s.err);
            end
        end
        if (ok_pulse === 1'b1 || err_pulse === 1'b1) begin
            checks++;
            if (event_q.size() == 0) begin
                errors++;
                $display("FAIL pulse @%0t: got ok=%b err=%b, need no pulse", $time, ok_pulse, err_pulse);
            end else begin
                exp_e = event_q.pop_front();
                if (ok_pulse !== exp_e.is_ok || err_pulse !== !exp_e.is_ok || state !== exp_e.st) begin
                    errors++;
                    $display("FAIL pulse @%0t: got ok=%b err=%b st=%0d, need ok=%b err=%b st=%0d",
                             $time, ok_pulse, err_pulse, state, exp_e.is_ok, !exp_e.is_ok, exp_e.st);
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        kif.key_valid = 1'b0;
        kif.key_code  = 4'h0;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("reset");
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // Correct default password unlocks.
        send_seq(32'h0001234d, 5);
        // Three wrong tries -> alarm, keys ignored, expiry, then unlock.
        send_seq(32'h0000000f, 1);
        send_seq(32'h0001235d, 5);
        send_seq(32'h0001235d, 5);
        send_seq(32'h0001235d, 5);
        send_seq(32'h0001234d, 5);
        idle(LOCKOUT);
        send_seq(32'h0001234d, 5);
        // Backspace editing, overflow digit, backspace to empty.
        send_seq(32'h0000000f, 1);
        send_seq(32'h0129b34d, 7);
        send_seq(32'h0000000f, 1);
        send_seq(32'h00012345, 5);
        send_seq(32'h0000000c, 1);
        send_seq(32'h0000007b, 2);
        // Password change, relock, old fails, new works.
        send_seq(32'h0001234d, 5);
        send_seq(32'h00e9876d, 6);
        send_seq(32'h0000000f, 1);
        send_seq(32'h0001234d, 5);
        send_seq(32'h0009876d, 5);
        // Short new password rejected, then SET_PW idle timeout.
        send_seq(32'h00000e5d, 3);
        idle(TIMEOUT + 2);
        // ENTRY idle timeout, then reset mid-entry (password reverts).
        send_seq(32'h0000000f, 1);
        send_seq(32'h00000012, 2);
        idle(TIMEOUT + 2);
        send_seq(32'h00000012, 2);
        mid_reset();
        send_seq(32'h0001234d, 5);
        // Back-to-back keys including one landing on the CHECK cycle.
        send_seq(32'h0000000f, 1);
        step(1'b1, 4'h1); step(1'b1, 4'h2); step(1'b1, 4'h3); step(1'b1, 4'h4);
        step(1'b1, 4'hd); step(1'b1, 4'hf); step(1'b1, 4'hf);
        idle(2);

        random_phase(300);
        idle(LOCKOUT + TIMEOUT);

        @(negedge clk);
        #1;
        checks++;
        if (event_q.size() != 0 || status_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pulses and %0d cycles unchecked, need 0 and 0", event_q.size(), status_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
